// File: rtl/sl_tx_queued_if.sv
// Word-offer channel of the queued SL transmitter: data, length and valid/ready handshake.
interface sl_tx_queued_if #(
  parameter int MAX_WIDTH = 32
);
  localparam int LW = $clog2(MAX_WIDTH + 1);

  logic [MAX_WIDTH-1:0] s_data;
  logic [LW-1:0]        s_len;
  logic                 s_valid;
  logic                 s_ready;

  modport master (output s_data, output s_len, output s_valid, input s_ready);
  modport slave  (input s_data, input s_len, input s_valid, output s_ready);
endinterface

// File: rtl/sl_tx_queued.sv
// Queued SL two-wire transmitter: a small word FIFO feeding an LSB-first serializer
// with a programmable phase length, odd/even line parity and a stop symbol.
module sl_tx_queued #(
  parameter int MAX_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  sl_tx_queued_if.slave                   bus,
  input  logic [DIV_WIDTH-1:0]            bit_div,
  input  logic                            en,
  output logic                            sl0,
  output logic                            sl1,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            err_len
);
  localparam int LW = $clog2(MAX_WIDTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_GAP    = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5,
    ST_TAIL   = 3'd6
  } state_t;

  // Parity after sending one more bit: par0 follows the zero count (seeded 1), par1 the one count.
  function automatic logic [1:0] par_update(input logic p0, input logic p1, input logic b);
    return {p0 ^ ~b, p1 ^ b};
  endfunction

  // Line levels {sl0, sl1} that belong to a state; the active line is pulled low.
  function automatic logic [1:0] line_levels(input state_t st, input logic b,
                                             input logic p0, input logic p1);
    logic [1:0] lv;
    case (st)
      ST_ACTIVE: lv = {b, ~b};
      ST_PARITY: lv = {p0, p1};
      ST_STOP:   lv = 2'b00;
      default:   lv = 2'b11;
    endcase
    return lv;
  endfunction

  logic [MAX_WIDTH-1:0] mem_data_r [FIFO_DEPTH];
  logic [LW-1:0]        mem_len_r  [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_r;
  logic [PW-1:0]        rd_ptr_r;
  logic [CW-1:0]        level_r;
  logic                 err_len_r;

  logic                 full_s;
  logic                 empty_s;
  logic                 offer_s;
  logic                 len_ok_s;
  logic                 push_s;
  logic                 pop_s;
  logic [MAX_WIDTH-1:0] head_data_s;
  logic [LW-1:0]        head_len_s;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [MAX_WIDTH-1:0] shift_r;
  logic [MAX_WIDTH-1:0] shift_nxt_s;
  logic [LW-1:0]        cnt_r;
  logic [LW-1:0]        cnt_nxt_s;
  logic [DIV_WIDTH-1:0] timer_r;
  logic [DIV_WIDTH-1:0] timer_nxt_s;
  logic [DIV_WIDTH-1:0] div_r;
  logic [DIV_WIDTH-1:0] div_nxt_s;
  logic                 par0_r;
  logic                 par1_r;
  logic [1:0]           par_nxt_s;
  logic                 phase_end_s;
  logic [1:0]           lines_nxt_s;
  logic                 sl0_r;
  logic                 sl1_r;

  assign full_s      = (level_r == CW'(FIFO_DEPTH));
  assign empty_s     = (level_r == {CW{1'b0}});
  assign offer_s     = bus.s_valid & ~full_s;
  assign len_ok_s    = (bus.s_len != {LW{1'b0}}) && (bus.s_len <= LW'(MAX_WIDTH));
  assign push_s      = offer_s & len_ok_s;
  assign head_data_s = mem_data_r[rd_ptr_r];
  assign head_len_s  = mem_len_r[rd_ptr_r];
  assign phase_end_s = (timer_r == {DIV_WIDTH{1'b0}});

  assign bus.s_ready = ~full_s;
  assign fifo_level  = level_r;
  assign err_len     = err_len_r;
  assign busy        = (state_r != ST_IDLE);
  assign sl0         = sl0_r;
  assign sl1         = sl1_r;

  // Word FIFO storage, pointers, occupancy and the illegal-length flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_r[i] <= {MAX_WIDTH{1'b0}};
        mem_len_r[i]  <= {LW{1'b0}};
      end
      wr_ptr_r  <= {PW{1'b0}};
      rd_ptr_r  <= {PW{1'b0}};
      level_r   <= {CW{1'b0}};
      err_len_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_data_r[wr_ptr_r] <= bus.s_data;
        mem_len_r[wr_ptr_r]  <= bus.s_len;
        wr_ptr_r             <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      if (push_s && !pop_s) begin
        level_r <= level_r + CW'(1);
      end else if (!push_s && pop_s) begin
        level_r <= level_r - CW'(1);
      end
      err_len_r <= offer_s & ~len_ok_s;
    end
  end

  // Sequencer next state; line levels are derived from the next state so they land with it.
  always_comb begin
    state_nxt_s = state_r;
    shift_nxt_s = shift_r;
    cnt_nxt_s   = cnt_r;
    div_nxt_s   = div_r;
    par_nxt_s   = {par0_r, par1_r};
    pop_s       = 1'b0;
    if (phase_end_s) begin
      timer_nxt_s = div_r;
    end else begin
      timer_nxt_s = timer_r - DIV_WIDTH'(1);
    end
    case (state_r)
      ST_IDLE: begin
        timer_nxt_s = timer_r;
        if (en && !empty_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        pop_s       = 1'b1;
        shift_nxt_s = head_data_s;
        cnt_nxt_s   = head_len_s;
        div_nxt_s   = bit_div;
        timer_nxt_s = bit_div;
        par_nxt_s   = par_update(1'b1, 1'b0, head_data_s[0]);
        state_nxt_s = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (phase_end_s) begin
          state_nxt_s = ST_GAP;
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      ST_GAP: begin
        if (phase_end_s) begin
          shift_nxt_s = shift_r >> 1;
          cnt_nxt_s   = cnt_r - LW'(1);
          if (cnt_r != LW'(1)) begin
            par_nxt_s   = par_update(par0_r, par1_r, shift_r[1]);
            state_nxt_s = ST_ACTIVE;
          end else begin
            state_nxt_s = ST_PARITY;
          end
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      ST_PARITY: begin
        if (phase_end_s) begin
          state_nxt_s = ST_STOP;
        end else begin
          state_nxt_s = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (phase_end_s) begin
          state_nxt_s = ST_TAIL;
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      ST_TAIL: begin
        if (phase_end_s && en && !empty_s) begin
          state_nxt_s = ST_LOAD;
        end else if (phase_end_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_TAIL;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    lines_nxt_s = line_levels(state_nxt_s, shift_nxt_s[0], par_nxt_s[1], par_nxt_s[0]);
  end

  // Sequencer state, datapath and registered line drivers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      shift_r <= {MAX_WIDTH{1'b0}};
      cnt_r   <= {LW{1'b0}};
      timer_r <= {DIV_WIDTH{1'b0}};
      div_r   <= {DIV_WIDTH{1'b0}};
      par0_r  <= 1'b1;
      par1_r  <= 1'b0;
      sl0_r   <= 1'b1;
      sl1_r   <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      shift_r <= shift_nxt_s;
      cnt_r   <= cnt_nxt_s;
      timer_r <= timer_nxt_s;
      div_r   <= div_nxt_s;
      par0_r  <= par_nxt_s[1];
      par1_r  <= par_nxt_s[0];
      sl0_r   <= lines_nxt_s[1];
      sl1_r   <= lines_nxt_s[0];
    end
  end
endmodule

// File: tb/tb_sl_tx_queued.sv
// Bench for sl_tx_queued: table of single words plus queueing, error, divider and reset sequences;
// a line monitor pops expected words from a scoreboard and compares every line sample.
module tb_sl_tx_queued;
  localparam int MW = 32;
  localparam int FD = 4;
  localparam int DW = 8;

  typedef struct {
    logic [31:0] data;
    int          len;
    int          div;
  } word_t;

  typedef struct {
    logic [31:0] data;
    int          len;
    int          div;
    int          exp_cycles;
    logic [1:0]  exp_par;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          en = 1'b0;
  logic [DW-1:0] bit_div = 8'd0;
  logic          sl0, sl1, busy, err_len;
  logic [2:0]    fifo_level;

  sl_tx_queued_if #(.MAX_WIDTH(MW)) bus ();

  sl_tx_queued #(.MAX_WIDTH(MW), .FIFO_DEPTH(FD), .DIV_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .bit_div(bit_div), .en(en),
    .sl0(sl0), .sl1(sl1), .busy(busy), .fifo_level(fifo_level), .err_len(err_len)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  word_t      sb_q[$];
  logic [1:0] trace_q[$];
  word_t      mon_w;
  bit         mon_on = 1'b0;
  int         mon_idx = 0;
  int         mon_bad = 0;
  int         par_idx = 0;
  int         words_done = 0;
  int         err_seen = 0;
  int         run_n = 0;
  logic [1:0] last_par = 2'b11;
  vec_t       vec[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a word begins when the lines leave idle; compare against the model trace.
  always @(negedge clk) begin
    if (!reset_n) begin
      mon_on = 1'b0;
    end else begin
      if (!mon_on && {sl0, sl1} != 2'b11) begin
        if (sb_q.size() == 0) begin
          check("unexpected_word_lines", {sl0, sl1}, 2'b11);
        end else begin
          int z, o;
          logic b;
          mon_w = sb_q.pop_front();
          trace_q.delete();
          z = 0;
          o = 0;
          for (int i = 0; i < mon_w.len; i++) begin
            b = mon_w.data[i];
            if (b) o++; else z++;
            for (int k = 0; k <= mon_w.div; k++) trace_q.push_back(b ? 2'b10 : 2'b01);
            for (int k = 0; k <= mon_w.div; k++) trace_q.push_back(2'b11);
          end
          for (int k = 0; k <= mon_w.div; k++) trace_q.push_back({1'b1 ^ z[0], o[0]});
          for (int k = 0; k <= mon_w.div; k++) trace_q.push_back(2'b00);
          for (int k = 0; k <= mon_w.div; k++) trace_q.push_back(2'b11);
          par_idx = 2 * mon_w.len * (mon_w.div + 1);
          mon_idx = 0;
          mon_bad = 0;
          mon_on = 1'b1;
        end
      end
      if (mon_on) begin
        if ({sl0, sl1} !== trace_q[mon_idx] || busy !== 1'b1) begin
          if (mon_bad == 0)
            $display("note: word %0h sample %0d lines=%b want %b busy=%b",
                     mon_w.data, mon_idx, {sl0, sl1}, trace_q[mon_idx], busy);
          mon_bad++;
        end
        if (mon_idx == par_idx) last_par = {sl0, sl1};
        mon_idx++;
        if (mon_idx == trace_q.size()) begin
          check("word_trace_mismatches", mon_bad, 0);
          words_done++;
          mon_on = 1'b0;
        end
      end
    end
  end

  // Count err_len pulses seen on the opposite edge.
  always @(negedge clk) begin
    if (err_len === 1'b1) err_seen++;
  end

  task automatic push(input logic [31:0] d, input int l, input int dv, input logic exp_ready);
    @(negedge clk);
    bus.s_data  = d;
    bus.s_len   = 6'(l);
    bus.s_valid = 1'b1;
    check("s_ready_at_push", bus.s_ready, exp_ready);
    if (exp_ready && l >= 1 && l <= MW) sb_q.push_back('{d, l, dv});
    @(posedge clk);
    #1 bus.s_valid = 1'b0;
  endtask

  task automatic run_len(output int n);
    int t;
    t = 0;
    n = 0;
    while (busy !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy !== 1'b1) begin
      check("busy_start_timeout", busy, 1'b1);
    end else begin
      while (busy === 1'b1 && n < 2000) begin
        n++;
        @(negedge clk);
      end
    end
  endtask

  task automatic wait_words(input int target);
    int t;
    t = 0;
    while (words_done < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("words_done", words_done, target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, e0, t;
    vec[0] = '{32'h0000_00A5,  8, 0,  20, 2'b10};
    vec[1] = '{32'h0000_001F,  5, 2,  40, 2'b11};
    vec[2] = '{32'h0000_0001,  1, 0,   6, 2'b11};
    vec[3] = '{32'h0000_0000,  1, 1,  11, 2'b00};
    vec[4] = '{32'hFFFF_FFFF, 32, 0,  68, 2'b10};
    vec[5] = '{32'h8000_0001, 32, 1, 135, 2'b10};
    vec[6] = '{32'h0000_0002,  3, 0,  10, 2'b11};
    bus.s_valid = 1'b0;
    bus.s_data  = 32'd0;
    bus.s_len   = 6'd0;

    repeat (3) @(negedge clk);
    check("rst_sl0", sl0, 1'b1);
    check("rst_sl1", sl1, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_level", fifo_level, 3'd0);
    check("rst_err_len", err_len, 1'b0);
    check("rst_s_ready", bus.s_ready, 1'b1);
    reset_n = 1'b1;
    @(negedge clk);

    en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bit_div = 8'(vec[i].div);
      push(vec[i].data, vec[i].len, vec[i].div, 1'b1);
      base = words_done;
      run_len(run_n);
      check($sformatf("busy_cycles[%0d]", i), run_n, vec[i].exp_cycles);
      check($sformatf("parity[%0d]", i), last_par, vec[i].exp_par);
      check($sformatf("words[%0d]", i), words_done, base + 1);
    end

    // Illegal lengths: rejected, one-clock err_len pulse each.
    bit_div = 8'd0;
    e0 = err_seen;
    push(32'h55, 0, 0, 1'b1);
    check("err_len_pulse_a", err_len, 1'b1);
    @(posedge clk);
    #1 check("err_len_low_a", err_len, 1'b0);
    push(32'h55, MW + 1, 0, 1'b1);
    check("err_len_pulse_b", err_len, 1'b1);
    @(posedge clk);
    #1 check("err_len_low_b", err_len, 1'b0);
    repeat (5) @(negedge clk);
    check("err_pulses", err_seen - e0, 2);
    check("err_level", fifo_level, 3'd0);
    check("err_lines", {sl0, sl1}, 2'b11);
    check("err_busy", busy, 1'b0);

    // Fill the FIFO with en low, then release: four words back-to-back in push order.
    en = 1'b0;
    base = words_done;
    push(32'h9, 4, 0, 1'b1);
    check("fill_level1", fifo_level, 3'd1);
    push(32'h6, 4, 0, 1'b1);
    check("fill_level2", fifo_level, 3'd2);
    push(32'hC, 4, 0, 1'b1);
    check("fill_level3", fifo_level, 3'd3);
    push(32'h3, 4, 0, 1'b1);
    check("fill_level4", fifo_level, 3'd4);
    check("full_s_ready", bus.s_ready, 1'b0);
    push(32'hF, 4, 0, 1'b0);
    check("full_level_after_refused", fifo_level, 3'd4);
    check("full_idle_lines", {sl0, sl1}, 2'b11);
    @(negedge clk);
    en = 1'b1;
    fork
      run_len(run_n);
      begin
        @(posedge clk);
        #1 check("load_level", fifo_level, 3'd4);
        @(posedge clk);
        #1 check("pop_level", fifo_level, 3'd3);
        check("pop_s_ready", bus.s_ready, 1'b1);
      end
    join
    check("b2b_busy_cycles", run_n, 48);
    check("b2b_words", words_done, base + 4);
    check("b2b_sb_empty", sb_q.size(), 0);

    // Divider change mid-word; second push lands on the pop edge of the first word.
    bit_div = 8'd0;
    base = words_done;
    push(32'hA5, 8, 0, 1'b1);
    @(negedge clk);
    push(32'h3C, 6, 3, 1'b1);
    check("pushpop_level", fifo_level, 3'd1);
    check("pushpop_busy", busy, 1'b1);
    repeat (4) @(negedge clk);
    bit_div = 8'd3;
    wait_words(base + 2);
    check("div_sb_empty", sb_q.size(), 0);
    repeat (3) @(negedge clk);
    check("div_idle", busy, 1'b0);

    // Reset during the active phase of bit 3, then a fresh word.
    bit_div = 8'd0;
    push(32'hA5, 8, 0, 1'b1);
    push(32'h77, 7, 0, 1'b1);
    t = 0;
    while (!(mon_on && mon_idx == 7) && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("reached_bit3", mon_idx, 7);
    check("bit3_lines", {sl0, sl1}, 2'b01);
    check("bit3_level", fifo_level, 3'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_sl0", sl0, 1'b1);
    check("midrst_sl1", sl1, 1'b1);
    check("midrst_level", fifo_level, 3'd0);
    check("midrst_busy", busy, 1'b0);
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    base = words_done;
    push(32'hA5, 8, 0, 1'b1);
    run_len(run_n);
    check("post_rst_busy_cycles", run_n, 20);
    check("post_rst_parity", last_par, 2'b10);
    check("post_rst_words", words_done, base + 1);
    check("final_sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
